wb_cim_test_hub: RTL and testbench
==================================

Name: wb_cim_test_hub

Overview:
- Parametrised Wishbone test hub sitting between the Caravel-style Wishbone slave bus and NCH Neuromorphic_X1_wb macro instances.
- Registers each bus request and routes it to one macro channel by address.
- Applies a programmable read-data offset (reset default +1), with a per-transaction ack timeout, transaction/timeout counters and a local CSR bank.
- Intended for silicon bring-up of multi-macro CIM tiles.

Parameters:
NCH, 2, number of downstream macro channels (1..8)
DW, 32, data width
CH_LSB, 16, LSB of channel-select field in wbs_adr_i (field width = clog2(NCH), min 1)
TIMEOUT, 255, max cycles waiting for downstream ack (1..65535)
RD_OFF_RST, 1, reset value of the RD_OFFSET CSR

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, asynchronous, active-low
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte select
wbs_adr_i  in  32  address
wbs_dat_i  in  DW  write data
wbs_dat_o  out  DW  read data
wbs_ack_o  out  1  ack, one-cycle pulse
m_cyc_o  out  NCH  per-channel cycle
m_stb_o  out  NCH  per-channel strobe
m_we_o  out  1  shared write enable
m_sel_o  out  4  shared byte select
m_adr_o  out  32  shared address (registered copy)
m_dat_o  out  DW  shared write data
m_dat_i  in  NCH*DW  per-channel read data, channel k at [k*DW +: DW]
m_ack_i  in  NCH  per-channel ack
irq_o  out  1  level; high while STATUS.TO_STICKY = 1

Behaviour:
- Reset (wb_rst_i=0, async): all outputs 0; FSM=IDLE; CTRL=0x1 (OFF_EN=1); RD_OFFSET=RD_OFF_RST; counters and STATUS = 0.
- Decode on wbs_adr_i[31:28]:
  - 4'hF: local CSR, offset [3:0].
  - Otherwise: channel ch = adr[CH_LSB +: CSW].
- CSRs (word access; wbs_sel_i ignored for CSRs):
  - 0x0 CTRL: bit0 OFF_EN. R/W.
  - 0x4 RD_OFFSET: DW bits. R/W.
  - 0x8 TXN_CNT: 32b. Counts completed channel transactions, wraps 0xFFFFFFFF→0. Any write clears it.
  - 0xC STATUS: [15:0] TO_CNT, saturating at 0xFFFF; bit16 TO_STICKY, write-1-clear; [23:20] last timed-out channel. Read-only except bit16.
  - Any other CSR offset: read 0, write ignored.
- FSM:
  - IDLE: on wbs_cyc_i & wbs_stb_i & !wbs_ack_o, capture adr/dat/sel/we and go to:
    - CSR if local.
    - ERR if ch >= NCH.
    - REQ otherwise.
  - REQ: m_cyc_o[ch] = m_stb_o[ch] = 1, all other bits 0; wait counter increments each cycle.
    - On m_ack_i[ch]=1: latch m_dat_i[ch] and go to RESP.
    - When the wait counter reaches TIMEOUT with no ack: deassert the strobe, go to TOUT.
    - Acks on non-selected channels are ignored.
  - RESP: wbs_ack_o=1 for one cycle.
    - Read: wbs_dat_o = latched data + RD_OFFSET (mod 2^DW) if OFF_EN, else the raw data.
    - Write: wbs_dat_o = 0.
    - TXN_CNT++. Return to IDLE.
  - CSR: perform the access; wbs_ack_o=1 one cycle; return to IDLE.
  - ERR: ack with wbs_dat_o=32'hDEAD_C0DE; no downstream activity; counters unchanged.
  - TOUT: ack with wbs_dat_o=32'hDEAD_BEEF; TO_CNT++ (saturating); TO_STICKY=1; record ch; return to IDLE.
- Latency:
  - Downstream ack in cycle k → wbs_ack_o in cycle k+1.
  - CSR / ERR: ack 2 cycles after the request is sampled.
- Master drops wbs_cyc_i mid-REQ: abort next cycle; downstream deasserted; no ack, no counter update.
- wbs_dat_o holds its value between acks.
- Reset asserted mid-transaction clears state immediately, with no ack.
- A STATUS write-1-clear in the same cycle as a TOUT set: the set wins.

Test Plan:
- Reset, read CSR 0x0/0x4/0x8/0xC → 0x1, 0x1, 0x0, 0x0; irq_o=0.
- Channel-1 read (adr 0x0001_0000), macro returns 0x0000_0041 with ack 3 cycles after request → m_cyc_o=2'b10; wbs_dat_o=0x42 one cycle after m_ack_i; TXN_CNT=1.
- Write RD_OFFSET=0xFFFF_FFFF, read data 0x0 → 0xFFFF_FFFF. Clear OFF_EN, read 0x10 → 0x10.
- No downstream ack, TIMEOUT=255 → ack with 0xDEAD_BEEF exactly 256 cycles after REQ entry; STATUS=0x0001_0001 with ch field set; irq_o=1. Write 0x0001_0000 to 0xC → irq_o=0, TO_CNT stays 1.
- NCH=2, access adr 0x0002_0000 → 0xDEAD_C0DE; no m_cyc_o activity; TXN_CNT unchanged.
- Drop wbs_cyc_i 2 cycles into REQ, and separately pulse wb_rst_i low mid-REQ → no wbs_ack_o; m_cyc_o=0 next cycle / immediately; next transaction completes normally.

Source files
------------

// File: rtl/wb_cim_test_hub.sv
// Wishbone test hub: registers each bus request, routes it to one of NCH CIM macro
// channels, adds a programmable read offset and times out silent macros.
module wb_cim_test_hub #(
    parameter int            NCH        = 2,
    parameter int            DW         = 32,
    parameter int            CH_LSB     = 16,
    parameter int            TIMEOUT    = 255,
    parameter logic [DW-1:0] RD_OFF_RST = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              wbs_ack_o,
    output logic [NCH-1:0]    m_cyc_o,
    output logic [NCH-1:0]    m_stb_o,
    output logic              m_we_o,
    output logic [3:0]        m_sel_o,
    output logic [31:0]       m_adr_o,
    output logic [DW-1:0]     m_dat_o,
    input  logic [NCH*DW-1:0] m_dat_i,
    input  logic [NCH-1:0]    m_ack_i,
    output logic              irq_o,
    output logic [2:0]        o_fsm_state
);

    localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [DW-1:0] ERR_WORD  = DW'(32'hDEAD_C0DE);
    localparam logic [DW-1:0] TOUT_WORD = DW'(32'hDEAD_BEEF);

    localparam logic [3:0] CSR_CTRL   = 4'h0;
    localparam logic [3:0] CSR_RD_OFF = 4'h4;
    localparam logic [3:0] CSR_TXN    = 4'h8;
    localparam logic [3:0] CSR_STATUS = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_CSR  = 3'd3,
        S_ERR  = 3'd4,
        S_TOUT = 3'd5
    } state_t;

    state_t              r_state;
    logic [31:0]         r_adr;
    logic [DW-1:0]       r_dat;
    logic [3:0]          r_sel;
    logic                r_we;
    logic [CSW-1:0]      r_ch;
    logic [WAIT_W-1:0]   r_wait;
    logic [NCH-1:0]      r_m_req;
    logic                r_ack;
    logic [DW-1:0]       r_dat_o;
    logic                r_off_en;
    logic [DW-1:0]       r_rd_off;
    logic [31:0]         r_txn;
    logic [15:0]         r_to_cnt;
    logic                r_to_sticky;
    logic [3:0]          r_last_ch;

    logic                w_req;
    logic                w_local;
    logic                w_ch_bad;
    logic [CSW-1:0]      w_ch_idx;
    logic [NCH-1:0]      w_onehot;
    logic [DW-1:0]       w_ch_dat [NCH];
    logic [DW-1:0]       w_sel_dat;
    logic                w_sel_ack;
    logic [DW-1:0]       w_rd_resp;
    logic [DW-1:0]       w_csr_rdata;

    // Upstream handshake: cyc&stb is a valid request, held until wbs_ack_o pulses for
    // one cycle; downstream cyc/stb on the selected channel is held until m_ack_i.
    assign w_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign w_local  = (wbs_adr_i[31:28] == 4'hF);
    assign w_ch_idx = wbs_adr_i[CH_LSB +: CSW];
    // Range check uses the whole field below the region nibble, so aliases above NCH error out.
    assign w_ch_bad = (32'(wbs_adr_i[27:CH_LSB]) >= NCH);

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_ch_dat[k] = m_dat_i[k*DW +: DW];
            w_onehot[k] = (w_ch_idx == CSW'(k));
        end
    end

    assign w_sel_dat = w_ch_dat[r_ch];
    assign w_sel_ack = m_ack_i[r_ch];
    assign w_rd_resp = r_off_en ? (w_sel_dat + r_rd_off) : w_sel_dat;

    always_comb begin
        w_csr_rdata = '0;
        case (r_adr[3:0])
            CSR_CTRL:   w_csr_rdata = DW'(r_off_en);
            CSR_RD_OFF: w_csr_rdata = r_rd_off;
            CSR_TXN:    w_csr_rdata = DW'(r_txn);
            CSR_STATUS: w_csr_rdata = DW'({8'h00, r_last_ch, 3'b000, r_to_sticky, r_to_cnt});
            default:    w_csr_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state     <= S_IDLE;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_ch        <= '0;
            r_wait      <= '0;
            r_m_req     <= '0;
            r_ack       <= 1'b0;
            r_dat_o     <= '0;
            r_off_en    <= 1'b1;
            r_rd_off    <= RD_OFF_RST;
            r_txn       <= '0;
            r_to_cnt    <= '0;
            r_to_sticky <= 1'b0;
            r_last_ch   <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr <= wbs_adr_i;
                        r_dat <= wbs_dat_i;
                        r_sel <= wbs_sel_i;
                        r_we  <= wbs_we_i;
                        r_ch  <= w_ch_idx;
                        if (w_local) begin
                            r_state <= S_CSR;
                        end else if (w_ch_bad) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_REQ;
                            r_m_req <= w_onehot;
                            r_wait  <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (!wbs_cyc_i) begin
                        r_m_req <= '0;
                        r_state <= S_IDLE;
                    end else if (w_sel_ack) begin
                        // Ack is raised here so it appears the cycle after the macro ack.
                        r_m_req <= '0;
                        r_ack   <= 1'b1;
                        r_dat_o <= r_we ? '0 : w_rd_resp;
                        r_txn   <= r_txn + 32'd1;
                        r_state <= S_RESP;
                    end else if (r_wait == WAIT_LAST) begin
                        r_m_req <= '0;
                        r_state <= S_TOUT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                S_CSR: begin
                    r_ack   <= 1'b1;
                    r_dat_o <= r_we ? '0 : w_csr_rdata;
                    if (r_we) begin
                        case (r_adr[3:0])
                            CSR_CTRL:   r_off_en <= r_dat[0];
                            CSR_RD_OFF: r_rd_off <= r_dat;
                            CSR_TXN:    r_txn    <= '0;
                            CSR_STATUS: if (r_dat[16]) r_to_sticky <= 1'b0;
                            default:    ;
                        endcase
                    end
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_ack   <= 1'b1;
                    r_dat_o <= ERR_WORD;
                    r_state <= S_IDLE;
                end
                S_TOUT: begin
                    r_ack       <= 1'b1;
                    r_dat_o     <= TOUT_WORD;
                    r_to_sticky <= 1'b1;
                    r_last_ch   <= 4'(r_ch);
                    if (r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_m_req <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_dat_o   = r_dat_o;
    assign wbs_ack_o   = r_ack;
    assign m_cyc_o     = r_m_req;
    assign m_stb_o     = r_m_req;
    assign m_we_o      = r_we;
    assign m_sel_o     = r_sel;
    assign m_adr_o     = r_adr;
    assign m_dat_o     = r_dat;
    assign irq_o       = r_to_sticky;
    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_wb_cim_test_hub.sv
// Bench for wb_cim_test_hub: directed vector table, hand sequences for abort/reset,
// and random transactions scored against a transaction-level model.
module tb_wb_cim_test_hub;

    localparam int NCH     = 2;
    localparam int DW      = 32;
    localparam int TIMEOUT = 255;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [DW-1:0]     wbs_dat_i;
    logic [DW-1:0]     wbs_dat_o;
    logic              wbs_ack_o;
    logic [NCH-1:0]    m_cyc_o, m_stb_o;
    logic              m_we_o;
    logic [3:0]        m_sel_o;
    logic [31:0]       m_adr_o;
    logic [DW-1:0]     m_dat_o;
    logic [NCH*DW-1:0] m_dat_i;
    logic [NCH-1:0]    m_ack_i;
    logic              irq_o;
    logic [2:0]        fsm_state;

    wb_cim_test_hub #(.NCH(NCH), .DW(DW), .CH_LSB(16), .TIMEOUT(TIMEOUT), .RD_OFF_RST(32'd1)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .irq_o(irq_o), .o_fsm_state(fsm_state)
    );

    // clock / watchdog
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // transaction-level reference model
    bit          md_off_en;
    logic [31:0] md_rd_off;
    logic [31:0] md_txn;
    int          md_to_cnt;
    bit          md_sticky;
    int          md_last_ch;

    task automatic model_reset();
        md_off_en = 1; md_rd_off = 32'd1; md_txn = 0;
        md_to_cnt = 0; md_sticky = 0; md_last_ch = 0;
    endtask

    task automatic model_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                             input int delay, input logic [31:0] mdat,
                             output logic [31:0] exp_dat, output int exp_lat, output logic [1:0] exp_mcyc);
        int chn;
        exp_dat = 0; exp_mcyc = 0; exp_lat = 2;
        chn = int'(adr[27:16]);
        if (adr[31:28] == 4'hF) begin
            if (we) begin
                case (adr[3:0])
                    4'h0: md_off_en = wdat[0];
                    4'h4: md_rd_off = wdat;
                    4'h8: md_txn = 0;
                    4'hC: if (wdat[16]) md_sticky = 0;
                    default: ;
                endcase
            end else begin
                case (adr[3:0])
                    4'h0: exp_dat = md_off_en;
                    4'h4: exp_dat = md_rd_off;
                    4'h8: exp_dat = md_txn;
                    4'hC: exp_dat = md_last_ch * 32'h10_0000 + md_sticky * 32'h1_0000 + md_to_cnt;
                    default: exp_dat = 0;
                endcase
            end
        end else if (chn >= NCH) begin
            exp_dat = 32'hDEAD_C0DE;
        end else if (delay >= 1 && delay <= TIMEOUT) begin
            exp_mcyc = 2'(1 << chn);
            exp_dat  = we ? 32'h0 : (md_off_en ? mdat + md_rd_off : mdat);
            md_txn   = md_txn + 1;
            exp_lat  = delay + 1;
        end else begin
            exp_mcyc   = 2'(1 << chn);
            exp_dat    = 32'hDEAD_BEEF;
            md_to_cnt  = (md_to_cnt == 65535) ? 65535 : md_to_cnt + 1;
            md_sticky  = 1;
            md_last_ch = chn;
            exp_lat    = TIMEOUT + 2;
        end
    endtask

    // driver: one full transaction with a behavioural macro answering after `delay` strobe cycles
    task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, input int delay, input logic [31:0] mdat,
                          input bit stray, output logic [31:0] rdat, output int lat,
                          output logic [1:0] mcyc);
        int  s;
        int  ch;
        bit  done;
        ch = int'(adr[16]);
        s = 0; lat = 0; mcyc = 0; rdat = 0; done = 0;
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = sel;
        m_dat_i = {$urandom, $urandom};
        m_dat_i[ch*DW +: DW] = mdat;
        wbs_cyc_i = 1; wbs_stb_i = 1;
        while (!done && lat < 600) begin
            @(negedge wb_clk_i);
            lat++;
            m_ack_i = '0;
            if (wbs_ack_o) begin
                rdat = wbs_dat_o;
                done = 1;
            end else begin
                mcyc |= m_cyc_o;
                if (m_stb_o[ch]) begin
                    s++;
                    if (s == 1) chk("m_bus", {m_adr_o, m_we_o, m_sel_o, m_dat_o}, {adr, we, sel, wdat});
                    if (s == delay) m_ack_i[ch] = 1'b1;
                end
                if (stray && $urandom_range(0, 2) == 0) m_ack_i[1-ch] = 1'b1;
            end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; m_ack_i = '0;
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_wait: no wbs_ack_o within 600 cycles for adr 0x%08h", adr);
        end
        @(negedge wb_clk_i);
        chk("ack_pulse", wbs_ack_o, 1'b0);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        int          delay;
        logic [31:0] mdat;
        logic [31:0] exp_dat;
        int          exp_lat;
        logic [1:0]  exp_mcyc;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] rdat, edat, adr, wdat;
        logic [1:0]  mcyc, emcyc;
        logic [3:0]  sel;
        logic        we;
        int          lat, elat, delay, r;
        bit          seen_ack;

        // directed table: adr, we, wdat, delay, mdat, exp_dat, exp_lat, exp_mcyc, exp_irq
        tbl.push_back('{32'hF000_0000, 1'b0, 32'h0, 0, 32'h0, 32'h1, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0004, 1'b0, 32'h0, 0, 32'h0, 32'h1, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0008, 1'b0, 32'h0, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_000C, 1'b0, 32'h0, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'h0001_0000, 1'b0, 32'h0, 3, 32'h41, 32'h42, 4, 2'b10, 1'b0});
        tbl.push_back('{32'hF000_0008, 1'b0, 32'h0, 0, 32'h0, 32'h1, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0004, 1'b1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'h0000_0010, 1'b0, 32'h0, 1, 32'h0, 32'hFFFF_FFFF, 2, 2'b01, 1'b0});
        tbl.push_back('{32'hF000_0000, 1'b1, 32'h0, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'h0000_0020, 1'b0, 32'h0, 2, 32'h10, 32'h10, 3, 2'b01, 1'b0});
        tbl.push_back('{32'h0001_0004, 1'b1, 32'h1234, 5, 32'h77, 32'h0, 6, 2'b10, 1'b0});
        tbl.push_back('{32'hF000_0008, 1'b0, 32'h0, 0, 32'h0, 32'h4, 2, 2'b00, 1'b0});
        tbl.push_back('{32'h0001_0000, 1'b0, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 257, 2'b10, 1'b1});
        tbl.push_back('{32'hF000_000C, 1'b0, 32'h0, 0, 32'h0, 32'h0011_0001, 2, 2'b00, 1'b1});
        tbl.push_back('{32'hF000_000C, 1'b1, 32'h0001_0000, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_000C, 1'b0, 32'h0, 0, 32'h0, 32'h0010_0001, 2, 2'b00, 1'b0});
        tbl.push_back('{32'h0002_0000, 1'b0, 32'h0, 1, 32'h0, 32'hDEAD_C0DE, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0008, 1'b0, 32'h0, 0, 32'h0, 32'h4, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0002, 1'b0, 32'h0, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0008, 1'b1, 32'hABCD, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0008, 1'b0, 32'h0, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0000, 1'b1, 32'h1, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'hF000_0004, 1'b1, 32'h5, 0, 32'h0, 32'h0, 2, 2'b00, 1'b0});
        tbl.push_back('{32'h0001_0000, 1'b0, 32'h0, 255, 32'h100, 32'h105, 256, 2'b10, 1'b0});

        // reset
        wb_rst_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0; m_dat_i = '0; m_ack_i = '0;
        model_reset();
        repeat (3) @(negedge wb_clk_i);
        chk("rst_outs", {wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, irq_o, m_adr_o},
            {1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0});
        wb_rst_i = 1;
        @(negedge wb_clk_i);

        foreach (tbl[i]) begin
            model_txn(tbl[i].adr, tbl[i].we, tbl[i].wdat, tbl[i].delay, tbl[i].mdat, edat, elat, emcyc);
            do_txn(tbl[i].adr, tbl[i].we, tbl[i].wdat, 4'hF, tbl[i].delay, tbl[i].mdat, 1'b1, rdat, lat, mcyc);
            chk($sformatf("vec%0d_dat", i), rdat, tbl[i].exp_dat);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_mcyc", i), mcyc, tbl[i].exp_mcyc);
            chk($sformatf("vec%0d_irq", i), irq_o, tbl[i].exp_irq);
        end

        // read data holds between acks
        repeat (3) @(negedge wb_clk_i);
        chk("dat_hold", wbs_dat_o, 32'h105);

        // master drops cyc two cycles into REQ
        wbs_adr_i = 32'h0001_0000; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_cyc_i = 1; wbs_stb_i = 1;
        repeat (2) @(negedge wb_clk_i);
        chk("drop_in_req", m_cyc_o, 2'b10);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge wb_clk_i);
        chk("drop_mcyc", m_cyc_o, 2'b00);
        seen_ack = 0;
        repeat (4) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) seen_ack = 1;
        end
        chk("drop_no_ack", seen_ack, 1'b0);
        model_txn(32'hF000_0008, 1'b0, 32'h0, 0, 32'h0, edat, elat, emcyc);
        do_txn(32'hF000_0008, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, rdat, lat, mcyc);
        chk("drop_txn_cnt", rdat, edat);

        // reset pulse mid-REQ
        wbs_adr_i = 32'h0000_0040; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
        repeat (2) @(negedge wb_clk_i);
        chk("rst_in_req", m_cyc_o, 2'b01);
        wb_rst_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
        #1;
        chk("rst_mid_outs", {m_cyc_o, wbs_ack_o, wbs_dat_o}, {2'b00, 1'b0, 32'h0});
        model_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1;
        @(negedge wb_clk_i);
        chk("rst_no_ack", wbs_ack_o, 1'b0);
        model_txn(32'h0000_0044, 1'b0, 32'h0, 2, 32'h99, edat, elat, emcyc);
        do_txn(32'h0000_0044, 1'b0, 32'h0, 4'hF, 2, 32'h99, 1'b0, rdat, lat, mcyc);
        chk("rst_next_dat", rdat, edat);
        chk("rst_next_lat", lat, elat);

        // random transactions against the model
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            wdat = $urandom;
            sel  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                adr = {4'hF, 24'($urandom), 4'($urandom_range(0, 15))};
            end else begin
                r   = $urandom_range(0, 9);
                adr = {4'($urandom_range(0, 14)),
                       (r == 0) ? 12'($urandom_range(2, 4095)) : 12'(r % 2),
                       16'($urandom)};
            end
            r = $urandom_range(0, 11);
            delay = (r == 0) ? -1 : (r == 1) ? TIMEOUT : $urandom_range(1, 8);
            model_txn(adr, we, wdat, delay, 32'($urandom), edat, elat, emcyc);
            exp_q.push_back(edat);
            // the model consumed the macro word; replay it through a fixed value instead
            if (!we && adr[31:28] != 4'hF && int'(adr[27:16]) < NCH && delay >= 1) begin
                void'(exp_q.pop_back());
                edat = md_off_en ? 32'h5A5A_0000 + n + md_rd_off : 32'h5A5A_0000 + n;
                exp_q.push_back(edat);
            end
            do_txn(adr, we, wdat, sel, delay, 32'h5A5A_0000 + n, 1'b1, rdat, lat, mcyc);
            chk($sformatf("rnd%0d_dat", n), rdat, exp_q.pop_front());
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            chk($sformatf("rnd%0d_mcyc", n), mcyc, emcyc);
            chk($sformatf("rnd%0d_irq", n), irq_o, md_sticky);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
